// File: rtl/sym_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one shared 2-bit-symbol unpacker
// from two byte sources; keeps the grant until the frame's symbols have drained.
module sym_frame_arbiter #(
    parameter int FRAME_BYTES = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ch0_valid,
    input  logic [7:0] ch0_byte,
    output logic       ch0_ready,
    input  logic       ch1_valid,
    input  logic [7:0] ch1_byte,
    output logic       ch1_ready,
    output logic       out_valid,
    output logic [7:0] out_byte,
    input  logic       out_ready,
    input  logic       sym_fire,
    output logic       active_ch,
    output logic       busy,
    output logic       frame_start,
    output logic       frame_done,
    output logic       err_underflw
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]       pending_q, pending_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;
    logic             byte_hs;
    logic             grant;

    // Datapath mux: only the granted channel sees out_ready, and only while in XFER.
    always_comb begin
        ch0_ready = 1'b0;
        ch1_ready = 1'b0;
        out_valid = 1'b0;
        out_byte  = '0;
        if (state_q == XFER) begin
            if (!active_q) begin
                out_valid = ch0_valid;
                ch0_ready = out_ready;
                if (ch0_valid) out_byte = ch0_byte;
            end else begin
                out_valid = ch1_valid;
                ch1_ready = out_ready;
                if (ch1_valid) out_byte = ch1_byte;
            end
        end
    end

    assign byte_hs = out_valid & out_ready;
    assign grant   = rr_q ? ch1_valid : ~ch0_valid;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        active_d      = active_q;
        byte_cnt_d    = byte_cnt_q;
        pending_d     = pending_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        err_d         = err_q;

        // Symbol credit tracking runs in every state, independent of the FSM.
        case ({byte_hs, sym_fire})
            2'b10: pending_d = pending_q + 4'd4;
            2'b11: pending_d = pending_q + 4'd3;
            2'b01: begin
                if (pending_q == 4'd0) err_d = 1'b1;
                else                   pending_d = pending_q - 4'd1;
            end
            default: pending_d = pending_q;
        endcase

        case (state_q)
            IDLE: begin
                if (ch0_valid || ch1_valid) begin
                    state_d       = XFER;
                    active_d      = grant;
                    frame_start_d = 1'b1;
                    byte_cnt_d    = '0;
                end
            end
            XFER: begin
                if (byte_hs) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d    = DRAIN;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if ((pending_q == 4'd0) || ((pending_q == 4'd1) && sym_fire)) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    rr_d         = ~active_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_q          <= 1'b0;
            active_q      <= 1'b0;
            byte_cnt_q    <= '0;
            pending_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            active_q      <= active_d;
            byte_cnt_q    <= byte_cnt_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
        end
    end

    assign active_ch    = active_q;
    assign busy         = (state_q != IDLE);
    assign frame_start  = frame_start_q;
    assign frame_done   = frame_done_q;
    assign err_underflw = err_q;

endmodule

// File: tb/tb_sym_frame_arbiter.sv
// Directed bench for sym_frame_arbiter with FRAME_BYTES=4: a vector table for the
// single-frame walk-through, then hand-written sequences for multi-cycle corners.
module tb_sym_frame_arbiter;

    localparam int FB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ch0_valid, ch1_valid, out_ready, sym_fire;
    logic [7:0] ch0_byte, ch1_byte, out_byte;
    logic       ch0_ready, ch1_ready, out_valid;
    logic       active_ch, busy, frame_start, frame_done, err_underflw;

    always #5 clk = ~clk;

    sym_frame_arbiter #(.FRAME_BYTES(FB), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ch0_valid(ch0_valid), .ch0_byte(ch0_byte), .ch0_ready(ch0_ready),
        .ch1_valid(ch1_valid), .ch1_byte(ch1_byte), .ch1_ready(ch1_ready),
        .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
        .sym_fire(sym_fire), .active_ch(active_ch), .busy(busy),
        .frame_start(frame_start), .frame_done(frame_done), .err_underflw(err_underflw)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       c0v;
        logic [7:0] c0b;
        logic       c1v;
        logic [7:0] c1b;
        logic       ordy;
        logic       sym;
        logic       e_busy, e_act, e_fs, e_fd, e_r0, e_r1, e_ov;
        logic [7:0] e_ob;
        logic       e_err;
    } vec_t;

    function automatic vec_t mk(input logic c0v, input logic [7:0] c0b, input logic c1v,
                                input logic [7:0] c1b, input logic ordy, input logic sym,
                                input logic e_busy, input logic e_act, input logic e_fs,
                                input logic e_fd, input logic e_r0, input logic e_r1,
                                input logic e_ov, input logic [7:0] e_ob, input logic e_err);
        vec_t v;
        v.c0v = c0v; v.c0b = c0b; v.c1v = c1v; v.c1b = c1b; v.ordy = ordy; v.sym = sym;
        v.e_busy = e_busy; v.e_act = e_act; v.e_fs = e_fs; v.e_fd = e_fd;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ov = e_ov; v.e_ob = e_ob; v.e_err = e_err;
        return v;
    endfunction

    // Bench-side source/sink model used by the hand-written sequences.
    int         tb_pend;
    int         i0, i1;
    logic [7:0] outq[$];
    logic       s_fs, s_fd, s_act, s_busy, s_r0, s_r1;

    task automatic do_reset();
        rst = 1'b1;
        ch0_valid = 1'b0; ch1_valid = 1'b0; ch0_byte = '0; ch1_byte = '0;
        out_ready = 1'b0; sym_fire = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tb_pend = 0; i0 = 0; i1 = 0;
        outq.delete();
    endtask

    // One clock: drive, sample mid-cycle, clock, update the model; returns at edge+1.
    task automatic run_cycle(input logic v0, input logic v1, input logic ordy);
        logic hs0, hs1, ohs, sym;
        ch0_valid = v0; ch0_byte = 8'h10 + 8'(i0);
        ch1_valid = v1; ch1_byte = 8'hB0 + 8'(i1);
        out_ready = ordy;
        sym = (tb_pend != 0);
        sym_fire = sym;
        #1;
        hs0 = ch0_valid & ch0_ready;
        hs1 = ch1_valid & ch1_ready;
        ohs = out_valid & out_ready;
        s_fs = frame_start; s_fd = frame_done; s_act = active_ch; s_busy = busy;
        s_r0 = ch0_ready; s_r1 = ch1_ready;
        if (ohs) outq.push_back(out_byte);
        @(posedge clk); #1;
        if (hs0) i0++;
        if (hs1) i1++;
        tb_pend = tb_pend + (ohs ? 4 : 0) - (sym ? 1 : 0);
    endtask

    initial begin
        vec_t tbl[$];
        logic grants[$];
        int   fd_count, bad, n;

        // Reset state
        rst = 1'b1;
        ch0_valid = 1'b0; ch1_valid = 1'b0; ch0_byte = '0; ch1_byte = '0;
        out_ready = 1'b0; sym_fire = 1'b0;
        tb_pend = 0; i0 = 0; i1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_active", active_ch, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_byte", out_byte, 8'h00);
        chk("rst_readys", {ch0_ready, ch1_ready}, 2'b00);
        chk("rst_pulses", {frame_start, frame_done}, 2'b00);
        chk("rst_err", err_underflw, 1'b0);
        rst = 1'b0;

        // Single ch0 frame E4,1B,00,FF with one sym_fire per cycle once symbols are owed
        tbl.push_back(mk(1, 8'hE4, 0, 8'h00, 1, 0,  0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 8'hE4, 0, 8'h00, 1, 0,  1, 0, 1, 0, 1, 0, 1, 8'hE4, 0));
        tbl.push_back(mk(1, 8'h1B, 0, 8'h00, 1, 1,  1, 0, 0, 0, 1, 0, 1, 8'h1B, 0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 1,  1, 0, 0, 0, 1, 0, 1, 8'h00, 0));
        tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 1, 1,  1, 0, 0, 0, 1, 0, 1, 8'hFF, 0));
        for (int k = 0; k < 13; k++)
            tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 1,  1, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 1, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 0, 0, 0, 8'h00, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            ch0_valid = tbl[k].c0v; ch0_byte = tbl[k].c0b;
            ch1_valid = tbl[k].c1v; ch1_byte = tbl[k].c1b;
            out_ready = tbl[k].ordy; sym_fire = tbl[k].sym;
            #1;
            chk($sformatf("v%0d_busy", k), busy, tbl[k].e_busy);
            chk($sformatf("v%0d_act", k), active_ch, tbl[k].e_act);
            chk($sformatf("v%0d_fs", k), frame_start, tbl[k].e_fs);
            chk($sformatf("v%0d_fd", k), frame_done, tbl[k].e_fd);
            chk($sformatf("v%0d_rdy", k), {ch0_ready, ch1_ready}, {tbl[k].e_r0, tbl[k].e_r1});
            chk($sformatf("v%0d_ov", k), out_valid, tbl[k].e_ov);
            chk($sformatf("v%0d_ob", k), out_byte, tbl[k].e_ob);
            chk($sformatf("v%0d_err", k), err_underflw, tbl[k].e_err);
            @(posedge clk); #1;
        end

        // Both channels always valid: grants alternate ch0, ch1, ch0
        do_reset();
        fd_count = 0; bad = 0; n = 0;
        while (fd_count < 3 && n < 300) begin
            run_cycle(1, 1, 1);
            n++;
            if (s_fs) grants.push_back(s_act);
            if (s_fd) fd_count++;
            if (s_busy && !s_act && s_r1) bad++;
            if (s_busy && s_act && s_r0) bad++;
        end
        chk("rr_frames_done", fd_count, 3);
        chk("rr_grant_count", grants.size(), 3);
        if (grants.size() == 3) begin
            chk("rr_grant0", grants[0], 1'b0);
            chk("rr_grant1", grants[1], 1'b1);
            chk("rr_grant2", grants[2], 1'b0);
        end
        chk("rr_idle_ready", bad, 0);

        // out_ready low for 5 cycles after 2 bytes
        do_reset();
        run_cycle(1, 0, 1);
        run_cycle(1, 0, 1);
        run_cycle(1, 0, 1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            run_cycle(1, 0, 0);
            if (s_r0 !== 1'b0) bad++;
            if (dut.byte_cnt_q !== 8'd2) bad++;
        end
        chk("stall_frozen", bad, 0);
        n = 0;
        while (!frame_done && n < 60) begin
            run_cycle(1, 0, 1);
            n++;
        end
        chk("stall_frame_done", frame_done, 1'b1);
        chk("stall_byte_count", outq.size(), FB);
        chk("stall_src_consumed", i0, FB);
        for (int k = 0; k < outq.size() && k < FB; k++)
            chk($sformatf("stall_byte%0d", k), outq[k], 8'h10 + 8'(k));

        // Handshake plus sym_fire with pending=2 -> pending=5
        do_reset();
        ch0_valid = 1'b1; ch0_byte = 8'h55; out_ready = 1'b1; sym_fire = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0; sym_fire = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pend_before", dut.pending_q, 4'd2);
        out_ready = 1'b1;
        #1;
        chk("pend_hs", out_valid & out_ready, 1'b1);
        @(posedge clk); #1;
        chk("pend_after", dut.pending_q, 4'd5);
        sym_fire = 1'b0; ch0_valid = 1'b0;

        // Reset during a ch1 frame after 2 bytes
        do_reset();
        n = 0;
        while (!frame_done && n < 60) begin
            run_cycle(1, 0, 1);
            n++;
        end
        chk("abort_pre_frame", frame_done, 1'b1);
        n = 0;
        while (i1 < 2 && n < 20) begin
            run_cycle(0, 1, 1);
            n++;
        end
        chk("abort_ch1_bytes", i1, 2);
        chk("abort_ch1_active", active_ch, 1'b1);
        rst = 1'b1; ch0_valid = 1'b1; ch1_valid = 1'b1; sym_fire = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_outs", {ch0_ready, ch1_ready, out_valid}, 3'b000);
        chk("abort_out_byte", out_byte, 8'h00);
        chk("abort_fd", frame_done, 1'b0);
        chk("abort_active", active_ch, 1'b0);
        chk("abort_pending", dut.pending_q, 4'd0);
        rst = 1'b0; tb_pend = 0;
        run_cycle(1, 1, 1);
        chk("abort_no_fd", s_fd, 1'b0);
        chk("abort_regrant_fs", frame_start, 1'b1);
        chk("abort_regrant_ch0", active_ch, 1'b0);
        chk("abort_cnt_restart", dut.byte_cnt_q, 8'd0);

        // sym_fire in IDLE with nothing pending
        do_reset();
        chk("uf_pre", err_underflw, 1'b0);
        sym_fire = 1'b1;
        @(posedge clk); #1;
        sym_fire = 1'b0;
        chk("uf_set", err_underflw, 1'b1);
        chk("uf_pend_zero", dut.pending_q, 4'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("uf_sticky", err_underflw, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("uf_cleared", err_underflw, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
